// File: rtl/gpio_write_arbiter.sv
// Arbitrates the external GPIO write port between a buffered CPU store path and a
// host request/grant path, presenting the winner through a valid/ready output register.
module gpio_write_arbiter #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_en,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_data,
  input  logic                       host_req,
  input  logic [ADDR_W-1:0]          host_addr,
  input  logic [DATA_W-1:0]          host_data,
  output logic                       host_gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_src,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                src_q, src_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];

  logic load, fifo_ne, host_win, sel_host, sel_cpu, push, pop;

  always_comb begin
    load     = (state_q == ST_EMPTY) || out_ready;
    fifo_ne  = (count_q != '0);
    host_win = host_req && (!fifo_ne || (starve_q != SW'(STARVE_MAX)));
    sel_host = load && host_win;
    sel_cpu  = load && fifo_ne && !host_win;
    pop      = sel_cpu;
    // A full FIFO can still take a write when the head leaves at the same edge.
    push     = cpu_en && ((count_q != CW'(DEPTH)) || pop);

    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    src_d      = src_q;
    starve_d   = starve_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q || (cpu_en && !push);

    if (load) begin
      if (sel_host) begin
        state_d = ST_HOLD;
        addr_d  = host_addr;
        data_d  = host_data;
        src_d   = 1'b1;
        if (!fifo_ne)
          starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
          starve_d = starve_q + SW'(1);
      end else if (sel_cpu) begin
        state_d          = ST_HOLD;
        {addr_d, data_d} = mem_q[rd_ptr_q];
        src_d            = 1'b0;
        starve_d         = '0;
      end else begin
        state_d  = ST_EMPTY;
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      addr_q     <= '0;
      data_q     <= '0;
      src_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      src_q      <= src_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {cpu_addr, cpu_data};
  end

  assign host_gnt   = sel_host && rst;
  assign out_valid  = (state_q == ST_HOLD);
  assign out_addr   = addr_q;
  assign out_data   = data_q;
  assign out_src    = src_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Scoreboard bench for gpio_write_arbiter: stimulus queues expected transfers,
// a negedge monitor compares every accepted output against the queue head.
module tb_gpio_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_en = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        host_req = 1'b0;
  logic [31:0] host_addr = '0;
  logic [7:0]  host_data = '0;
  logic        host_gnt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [7:0]  out_data;
  logic        out_src;
  logic [3:0]  fifo_count;
  logic        overflow;

  typedef struct packed {
    logic        src;
    logic [31:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  gpio_write_arbiter #(.DEPTH(8), .ADDR_W(32), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_gnt(host_gnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_src(out_src),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every transfer (valid & ready sampled away from the edge) is checked against the queue head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_txn: got src=%0d addr=0x%0h data=0x%0h, expected none",
                 out_src, out_addr, out_data);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        if ({out_src, out_addr, out_data} !== e) begin
          n_err++;
          $display("[TB] FAIL txn: got src=%0d addr=0x%0h data=0x%0h, expected src=%0d addr=0x%0h data=0x%0h",
                   out_src, out_addr, out_data, e.src, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cpu_en = 1'b0;
    host_req = 1'b0;
    out_ready = 1'b0;
    #1;
    check_output("rst_valid", 64'(out_valid), 64'd0);
    check_output("rst_count", 64'(fifo_count), 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    check_output("rst_gnt", 64'(host_gnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [7:0] d);
    cpu_en = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    step();
    cpu_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < 200) begin
      step();
      cyc++;
    end
    repeat (2) step();
    check_output(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int grants;
    logic g;

    // Single CPU write latency
    do_reset();
    out_ready = 1'b1;
    cpu_en = 1'b1; cpu_addr = 32'h100; cpu_data = 8'hA5;
    exp_q.push_back({1'b0, 32'h100, 8'hA5});
    step();
    cpu_en = 1'b0;
    check_output("lat_count1", 64'(fifo_count), 64'd1);
    check_output("lat_valid1", 64'(out_valid), 64'd0);
    step();
    check_output("lat_valid2", 64'(out_valid), 64'd1);
    check_output("lat_addr", 64'(out_addr), 64'h100);
    check_output("lat_data", 64'(out_data), 64'hA5);
    check_output("lat_src", 64'(out_src), 64'd0);
    check_output("lat_count2", 64'(fifo_count), 64'd0);
    drain("drain_lat");

    // Overflow: ten writes with the output stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back({1'b0, 32'(32'h200 + i), 8'(i)});
      apply_stimulus(32'(32'h200 + i), 8'(i));
    end
    check_output("ovf_count", 64'(fifo_count), 64'd8);
    check_output("ovf_flag", 64'(overflow), 64'd1);
    check_output("ovf_hold_data", 64'(out_data), 64'd0);
    drain("drain_ovf");
    check_output("ovf_sticky", 64'(overflow), 64'd1);

    // Host request with idle output
    do_reset();
    out_ready = 1'b1;
    host_req = 1'b1; host_addr = 32'h200; host_data = 8'h3C;
    exp_q.push_back({1'b1, 32'h200, 8'h3C});
    #1;
    check_output("host_gnt", 64'(host_gnt), 64'd1);
    step();
    host_req = 1'b0;
    check_output("host_valid", 64'(out_valid), 64'd1);
    check_output("host_src", 64'(out_src), 64'd1);
    check_output("host_data", 64'(out_data), 64'h3C);
    drain("drain_host");

    // Push and pop at the same edge while full
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({1'b0, 32'(32'h300 + i), 8'(8'h40 + i)});
      apply_stimulus(32'(32'h300 + i), 8'(8'h40 + i));
    end
    check_output("full_count", 64'(fifo_count), 64'd8);
    exp_q.push_back({1'b0, 32'h399, 8'h99});
    out_ready = 1'b1;
    apply_stimulus(32'h399, 8'h99);
    check_output("pp_count", 64'(fifo_count), 64'd8);
    check_output("pp_overflow", 64'(overflow), 64'd0);
    drain("drain_pp");

    // Starvation guard: host held, three entries waiting behind the output register
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      apply_stimulus(32'(32'h400 + i), 8'(8'h50 + i));
    check_output("starve_count", 64'(fifo_count), 64'd3);
    exp_q.push_back({1'b0, 32'h400, 8'h50});
    for (int c = 0; c < 3; c++) begin
      for (int h = 0; h < 4; h++)
        exp_q.push_back({1'b1, 32'h500, 8'(8'h10 + c * 4 + h)});
      exp_q.push_back({1'b0, 32'(32'h401 + c), 8'(8'h51 + c)});
    end
    host_addr = 32'h500; host_data = 8'h10; host_req = 1'b1;
    out_ready = 1'b1;
    grants = 0;
    for (int cyc = 0; cyc < 100 && grants < 12; cyc++) begin
      @(negedge clk);
      g = host_gnt;
      step();
      if (g) begin
        grants++;
        host_data = host_data + 8'd1;
        if (grants == 12) host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    check_output("starve_grants", 64'(grants), 64'd12);
    drain("drain_starve");

    // Asynchronous reset mid-transfer discards everything
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      apply_stimulus(32'(32'h600 + i), 8'(8'h60 + i));
    check_output("mid_count", 64'(fifo_count), 64'd5);
    check_output("mid_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("ar_valid", 64'(out_valid), 64'd0);
    check_output("ar_count", 64'(fifo_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    check_output("post_valid", 64'(out_valid), 64'd0);
    check_output("post_count", 64'(fifo_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
